// File: rtl/conv_systolic_engine.sv
// conv_systolic_engine: valid 2-D correlation of an IN_DIM x IN_DIM tile with a
// K_DIM x K_DIM filter on an OUT_DIM x OUT_DIM output-stationary PE grid.
// One filter tap is broadcast per cycle; every PE accumulates its own window
// element times that weight, then a finishing cycle applies optional ReLU and
// saturation/truncation to OUT_W.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-low reset
//   start     job request, honoured only while idle
//   mode      bit0 ReLU enable, bit1 saturate (else truncate); captured with start
//   in_flat   input tile, element (r,c) at [(r*IN_DIM+c)*DATA_W +: DATA_W]
//   filt_flat filter, same row-major packing
//   busy      high while a job is in flight
//   done      one-cycle pulse when out_flat is updated
//   out_flat  results, row-major, held until the next done or reset
module conv_systolic_engine #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IN_DIM = 4,
    parameter int unsigned K_DIM  = 3,
    parameter int unsigned OUT_W  = 16,
    parameter bit          SIGNED = 1'b1
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  start,
    input  logic [1:0]                                            mode,
    input  logic [IN_DIM*IN_DIM*DATA_W-1:0]                       in_flat,
    input  logic [K_DIM*K_DIM*DATA_W-1:0]                         filt_flat,
    output logic                                                  busy,
    output logic                                                  done,
    output logic [(IN_DIM-K_DIM+1)*(IN_DIM-K_DIM+1)*OUT_W-1:0]    out_flat
);

    localparam int unsigned OUT_DIM = IN_DIM - K_DIM + 1;
    localparam int unsigned TAPS    = K_DIM * K_DIM;
    localparam int unsigned TAP_W   = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int unsigned PROD_W  = 2 * DATA_W;
    localparam int unsigned ACC_W   = 2 * DATA_W + $clog2(TAPS) + 1;
    localparam int unsigned IN_BITS = IN_DIM * IN_DIM * DATA_W;
    localparam int unsigned F_BITS  = TAPS * DATA_W;
    // One bit wider than both the accumulator and the result so clamp bounds
    // and the accumulator compare as signed values without overflow.
    localparam int unsigned WIDE_W  = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

    localparam logic signed [WIDE_W-1:0] SAT_HI = SIGNED
        ? ((WIDE_W'(1) << (OUT_W - 1)) - WIDE_W'(1))
        : ((WIDE_W'(1) << OUT_W) - WIDE_W'(1));
    localparam logic signed [WIDE_W-1:0] SAT_LO = SIGNED
        ? (-(WIDE_W'(1) << (OUT_W - 1)))
        : WIDE_W'(0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [TAP_W-1:0]     tap_q, tap_d;
    logic [IN_BITS-1:0]   in_q, in_d;
    logic [F_BITS-1:0]    filt_q, filt_d;
    logic [1:0]           mode_q, mode_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 acc_clr_c, acc_en_c, out_ld_c;

    // ReLU then saturate/truncate one accumulator to OUT_W.
    function automatic logic [OUT_W-1:0] reduce(input logic [ACC_W-1:0] acc,
                                                input logic [1:0]       md);
        logic signed [WIDE_W-1:0] v;
        v = {{(WIDE_W-ACC_W){SIGNED & acc[ACC_W-1]}}, acc};
        if (md[0] && SIGNED && v[WIDE_W-1]) begin
            v = '0;
        end
        if (md[1]) begin
            if (v > SAT_HI) begin
                v = SAT_HI;
            end else if (v < SAT_LO) begin
                v = SAT_LO;
            end
        end
        return v[OUT_W-1:0];
    endfunction

    // Next-state and control strobes.
    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        in_d      = in_q;
        filt_d    = filt_q;
        mode_d    = mode_q;
        done_d    = 1'b0;
        acc_clr_c = 1'b0;
        acc_en_c  = 1'b0;
        out_ld_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    in_d      = in_flat;
                    filt_d    = filt_flat;
                    mode_d    = mode;
                    tap_d     = '0;
                    acc_clr_c = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                acc_en_c = 1'b1;
                if (tap_q == TAP_W'(TAPS - 1)) begin
                    state_d = FIN;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            FIN: begin
                out_ld_c = 1'b1;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Control and operand registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            tap_q   <= '0;
            in_q    <= '0;
            filt_q  <= '0;
            mode_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            in_q    <= in_d;
            filt_q  <= filt_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    // Weight broadcast: current tap's filter element, extended to product width.
    logic [DATA_W-1:0] filt_a [TAPS];
    logic [DATA_W-1:0] w_c;
    logic [PROD_W-1:0] w_ext_c;

    for (genvar t = 0; t < TAPS; t++) begin : g_filt
        assign filt_a[t] = filt_q[t*DATA_W +: DATA_W];
    end

    assign w_c     = filt_a[tap_q];
    assign w_ext_c = {{DATA_W{SIGNED & w_c[DATA_W-1]}}, w_c};

    // PE grid: each PE prewires its K_DIM x K_DIM window and picks the element
    // matching the broadcast tap.
    for (genvar i = 0; i < OUT_DIM; i++) begin : g_row
        for (genvar j = 0; j < OUT_DIM; j++) begin : g_col
            logic [DATA_W-1:0] win [TAPS];
            logic [DATA_W-1:0] x_c;
            logic [PROD_W-1:0] x_ext_c, prod_c;
            logic [ACC_W-1:0]  prod_ext_c;
            logic [ACC_W-1:0]  acc_q, acc_d;
            logic [OUT_W-1:0]  out_q, out_d;

            for (genvar ky = 0; ky < K_DIM; ky++) begin : g_ky
                for (genvar kx = 0; kx < K_DIM; kx++) begin : g_kx
                    assign win[ky*K_DIM+kx] =
                        in_q[((i+ky)*IN_DIM + (j+kx))*DATA_W +: DATA_W];
                end
            end

            assign x_c        = win[tap_q];
            assign x_ext_c    = {{DATA_W{SIGNED & x_c[DATA_W-1]}}, x_c};
            // Low PROD_W bits of the extended product are exact in either signedness.
            assign prod_c     = x_ext_c * w_ext_c;
            assign prod_ext_c = {{(ACC_W-PROD_W){SIGNED & prod_c[PROD_W-1]}}, prod_c};

            always_comb begin
                acc_d = acc_q;
                out_d = out_q;
                if (acc_clr_c) begin
                    acc_d = '0;
                end else if (acc_en_c) begin
                    acc_d = acc_q + prod_ext_c;
                end
                if (out_ld_c) begin
                    out_d = reduce(acc_q, mode_q);
                end
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    acc_q <= '0;
                    out_q <= '0;
                end else begin
                    acc_q <= acc_d;
                    out_q <= out_d;
                end
            end

            assign out_flat[(i*OUT_DIM+j)*OUT_W +: OUT_W] = out_q;
        end
    end

endmodule
